// File: rtl/m_proc_mc_if.sv
`default_nettype none
// ==== m_proc_mc_if : retire/writeback observation bundle of m_proc_mc | rev 1.0 ====
interface m_proc_mc_if;
  logic [31:0] w_pc;
  logic        w_retire;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_rt;
  logic        w_halt;

  modport master (output w_pc, w_retire, w_we, w_wa, w_rt, w_halt);
  modport slave  (input  w_pc, w_retire, w_we, w_wa, w_rt, w_halt);
endinterface
`default_nettype wire

// File: rtl/m_proc_mc.sv
`default_nettype none
// ==== m_proc_mc : multi-cycle RV32I-subset core (IF/ID/EX/MEM/WB/HALT) | rev 1.0 ====
module m_proc_mc #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          HALT_REG   = 30
) (
  input  wire logic   w_clk,
  input  wire logic   w_rst,
  m_proc_mc_if.master bus
);
  localparam int         c_IW      = $clog2(IMEM_DEPTH);
  localparam int         c_DW      = $clog2(DMEM_DEPTH);
  localparam logic [4:0] c_HALT_RA = 5'(HALT_REG);

  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_LUI = 7'b0110111;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;
  localparam logic [6:0] c_OP_LD  = 7'b0000011;
  localparam logic [6:0] c_OP_ST  = 7'b0100011;
  localparam logic [6:0] c_OP_BR  = 7'b1100011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Program and data storage are preloaded hierarchically; reset leaves them alone.
  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] dmem [0:DMEM_DEPTH-1];
  logic [31:0] r_rf [0:31];

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_imm;
  logic [31:0] r_alu;
  logic [31:0] r_npc;
  logic        r_retire;
  logic        r_we;
  logic [4:0]  r_wa;
  logic [31:0] r_rt;
  logic        r_halt;

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic        w_is_add, w_is_sub, w_is_addi, w_is_lui, w_is_jal;
  logic        w_is_lw, w_is_sw, w_is_br;
  logic        w_to_wb, w_to_mem;
  logic [31:0] w_imm;
  logic        w_taken;
  logic [31:0] w_res;
  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_unused_bits;

  assign w_opc = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  assign w_is_add  = (w_opc == c_OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
  assign w_is_sub  = (w_opc == c_OP_R) && (w_f3 == 3'b000) && (w_f7 == 7'b0100000);
  assign w_is_addi = (w_opc == c_OP_I) && (w_f3 == 3'b000);
  assign w_is_lui  = (w_opc == c_OP_LUI);
  assign w_is_jal  = (w_opc == c_OP_JAL);
  assign w_is_lw   = (w_opc == c_OP_LD) && (w_f3 == 3'b010);
  assign w_is_sw   = (w_opc == c_OP_ST) && (w_f3 == 3'b010);
  assign w_is_br   = (w_opc == c_OP_BR) &&
                     ((w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                      (w_f3 == 3'b100) || (w_f3 == 3'b101));
  assign w_to_wb   = w_is_add | w_is_sub | w_is_addi | w_is_lui | w_is_jal;
  assign w_to_mem  = w_is_lw | w_is_sw;

  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    case (w_opc)
      c_OP_ST:  w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      c_OP_BR:  w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      c_OP_LUI: w_imm = {r_ir[31:12], 12'b0};
      c_OP_JAL: w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      default:  w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_taken = (r_a == r_b);
      3'b001:  w_taken = (r_a != r_b);
      3'b100:  w_taken = ($signed(r_a) <  $signed(r_b));
      3'b101:  w_taken = ($signed(r_a) >= $signed(r_b));
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_res = r_a + r_imm;
    if (w_is_add)      w_res = r_a + r_b;
    else if (w_is_sub) w_res = r_a - r_b;
    else if (w_is_lui) w_res = r_imm;
    else if (w_is_jal) w_res = w_pc4;
  end

  assign w_pc4    = r_pc + 32'd4;
  assign w_target = (r_pc + r_imm) & ~32'd1;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= S_IF;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_alu    <= '0;
      r_npc    <= '0;
      r_retire <= 1'b0;
      r_we     <= 1'b0;
      r_wa     <= '0;
      r_rt     <= '0;
      r_halt   <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        S_IF: begin
          r_ir    <= imem[r_pc[c_IW+1:2]];
          r_state <= S_ID;
        end
        S_ID: begin
          r_a      <= r_rf[w_rs1];
          r_b      <= r_rf[w_rs2];
          r_imm    <= w_imm;
          r_state  <= S_EX;
          // Branches and unsupported words finish in EX, so their retire pulse starts now.
          r_retire <= !(w_to_wb || w_to_mem);
        end
        S_EX: begin
          if (w_to_mem) begin
            r_alu    <= r_a + r_imm;
            r_retire <= w_is_sw;
            r_state  <= S_MEM;
          end else if (w_to_wb) begin
            r_alu    <= w_res;
            r_rt     <= w_res;
            r_we     <= 1'b1;
            r_wa     <= w_rd;
            r_retire <= 1'b1;
            r_npc    <= w_is_jal ? w_target : w_pc4;
            r_state  <= S_WB;
          end else begin
            r_pc    <= (w_is_br && w_taken) ? w_target : w_pc4;
            r_state <= S_IF;
          end
        end
        S_MEM: begin
          if (w_is_lw) begin
            r_rt     <= dmem[r_alu[c_DW+1:2]];
            r_we     <= 1'b1;
            r_wa     <= w_rd;
            r_retire <= 1'b1;
            r_npc    <= w_pc4;
            r_state  <= S_WB;
          end else begin
            r_pc    <= w_pc4;
            r_state <= S_IF;
          end
        end
        S_WB: begin
          if (r_wa != 5'd0) r_rf[r_wa] <= r_rt;
          // A halting writeback leaves the PC on the halting instruction.
          if (r_wa == c_HALT_RA) begin
            r_halt  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_pc    <= r_npc;
            r_state <= S_IF;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: r_state <= S_IF;
      endcase
    end
  end

  // Reset forces the FSM out of MEM asynchronously, so an aborted store never lands.
  always_ff @(posedge w_clk) begin
    if (r_state == S_MEM && w_is_sw) dmem[r_alu[c_DW+1:2]] <= r_b;
  end

  assign w_unused_bits = &{1'b0, r_pc[1:0], r_pc[31:c_IW+2], r_alu[1:0], r_alu[31:c_DW+2]};

  assign bus.w_pc     = r_pc;
  assign bus.w_retire = r_retire;
  assign bus.w_we     = r_we;
  assign bus.w_wa     = r_wa;
  assign bus.w_rt     = r_rt;
  assign bus.w_halt   = r_halt;
endmodule
`default_nettype wire

// File: doc/m_proc_mc.md
Name: m_proc_mc

Overview:
- Parametrised multi-cycle RV32I-subset processor; successor to the single-cycle core.
- Each instruction is sequenced through an FSM (fetch, decode, execute, memory, writeback), so one ALU and one memory port are shared across cycles.
- Adds the following, which the single-cycle core lacks:
  - asynchronous reset
  - a real taken-branch path
  - JAL, LUI, SUB and BEQ/BLT/BGE
  - a halt state
  - retire observability
- Sits under the testbench top as the processor instance.

Parameters:
- IMEM_DEPTH, 64, instruction memory words (power of 2).
- DMEM_DEPTH, 64, data memory words (power of 2).
- RESET_PC, 32'h0, PC value loaded on reset.
- HALT_REG, 30, a writeback to this register index halts the core.

Ports:
- w_clk  input  1  clock; all state updates on the rising edge.
- w_rst  input  1  asynchronous, active-high reset.
- w_pc  output  32  current PC register.
- w_retire  output  1  one-cycle pulse in the final state of each instruction.
- w_we  output  1  register-file write strobe, valid in the WB state.
- w_wa  output  5  register-file write address.
- w_rt  output  32  register-file write data.
- w_halt  output  1  high while in the HALT state.

Behaviour:
- Storage:
  - Internal arrays imem[0:IMEM_DEPTH-1] and dmem[0:DMEM_DEPTH-1] are loaded by the bench through hierarchical reference. Reset does not clear them.
  - Word index is addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap.
  - The register file has 32x32 entries. x0 always reads 0, and writes to x0 are dropped (w_we still pulses, but there is no effect).
- Reset (asynchronous):
  - state=IF, pc=RESET_PC, and all RF entries = 0.
  - Outputs are 0 except w_pc=RESET_PC.
  - Reset asserted mid-instruction aborts it with no RF or dmem write.
- FSM states: IF, ID, EX, MEM, WB, HALT. One cycle per state.
  - IF: ir <= imem[pc].
  - ID: latch rs1/rs2 data and the decoded immediate (I/S/B/U/J formats, sign-extended).
  - EX: alu <= result.
    - Branches resolve here: pc <= taken ? pc+immB : pc+4, then go to IF and pulse w_retire.
  - MEM:
    - lw: mdr <= dmem[alu].
    - sw: dmem[alu] <= rs2 at this edge, pc+=4, go to IF, pulse w_retire.
  - WB: RF[rd] <= w_rt, w_we=1, pc <= next_pc, pulse w_retire.
    - If rd==HALT_REG, go to HALT; otherwise go to IF.
  - HALT: all state is frozen, w_halt=1, and the core leaves HALT only on reset.
- Per-instruction sequences and WB data:
  - add/sub/addi: IF-ID-EX-WB (4 cycles). rd=rs1±op2.
  - lui: IF-ID-EX-WB (4 cycles). rd=immU.
  - jal: IF-ID-EX-WB (4 cycles). rd=pc+4, next_pc=pc+immJ.
  - lw: IF-ID-EX-MEM-WB (5 cycles). rd=mdr.
  - sw: IF-ID-EX-MEM (4 cycles).
  - beq/bne/blt/bge: IF-ID-EX (3 cycles). blt/bge compare signed.
- Unsupported opcode or funct: treated as a 3-cycle NOP (IF-ID-EX); pc+=4 with no writes.
- Arithmetic: 32-bit, with silent wrap-around and no traps. Branch and jump targets are PC-relative; bit 0 is forced to 0.
- w_wa, w_rt and w_we are registered combinationally from state and are meaningful only when state==WB.

Test Plan:
- Loop program, run after reset release:
  - Program: addi x1,x0,5; add x2,x1,x1; L: addi x1,x1,1; bne x1,x2,L; addi x30,x1,9.
  - Required: w_halt rises after rising edge 47; 13 w_retire pulses; RF x1=10, x2=10, x30=19; w_pc frozen at 0x10.
- Memory round trip:
  - Program: addi x5,x0,-3; sw x5,8(x0); lw x6,8(x0).
  - Required: dmem[2]=0xFFFFFFFD; x6=0xFFFFFFFD; the lw occupies exactly 5 cycles.
- jal and lui:
  - Program: lui x7,0x12345 at pc=0; jal x8,+8 at pc=4.
  - Required: x7=0x12345000, x8=8, next fetch from pc=0xC.
- x0 write and unknown opcode:
  - Program: addi x0,x0,7, followed by word 0xFFFFFFFF.
  - Required: x0 reads 0; the unknown word takes 3 cycles with no w_we; pc advances by 4.
- Asynchronous reset mid-lw:
  - Stimulus: assert w_rst during MEM of a lw to x9, between clock edges.
  - Required: immediately pc=RESET_PC and w_halt=0; x9 is unchanged; execution restarts at IF after deassertion.
- Signed branch:
  - Program: x1=-1, x2=1; blt x1,x2,+12.
  - Required: taken, pc+12.
  - Companion case: bge x1,x2 is not taken, pc+4.
